fft_frame_sequencer: RTL
========================

Name: fft_frame_sequencer

Overview:
- Sits between the Hanning window output and the streaming FFT core.
- Buffers windowed audio samples in a small FIFO and streams exactly FFT_SIZE samples per frame into the FFT input handshake, asserting last on sample FFT_SIZE-1.
- Then drains the FFT output stream, tagging each bin with its index, and counts completed frames.
- Absorbs FFT input backpressure and reports dropped samples.

Parameters:
- FFT_SIZE, 4096: samples per frame; power of two, 8..65536.
- SAMPLE_WIDTH, 8: signed audio sample width.
- FIFO_DEPTH, 16: sample buffer entries; power of two, >=2.

Ports:
- clk_in  in  1  system clock (100 MHz)
- rst_in  in  1  synchronous active-high reset
- in_sample  in  SAMPLE_WIDTH  signed windowed sample
- audio_sample_valid  in  1  one-cycle strobe; in_sample valid
- fft_in_data  out  2*SAMPLE_WIDTH  {imag=0, real=sample}; real in low half
- fft_in_valid  out  1  FFT input valid
- fft_in_last  out  1  marks sample FFT_SIZE-1 of frame
- fft_ready  in  1  FFT input ready
- fft_out_valid  in  1  FFT output valid
- fft_out_last  in  1  FFT output last
- fft_out_ready  out  1  sequencer accepts FFT output
- bin_valid  out  1  equals fft_out_valid & fft_out_ready
- bin_index  out  $clog2(FFT_SIZE)  index of current output bin
- frame_done  out  1  one-cycle pulse after final bin accepted
- frame_count  out  16  completed frames, wraps at 65535->0
- overflow  out  1  sticky: sample dropped on full FIFO
- seq_error  out  1  sticky output-length mismatch (see Optional Feature)
- busy  out  1  high while state is UNLOAD

Behaviour:
- Reset (synchronous, wins over all other events):
  - FIFO emptied; state FEED.
  - in_idx=0, bin_index=0, frame_count=0.
  - fft_in_valid=0, fft_in_last=0, fft_out_ready=0, frame_done=0, overflow=0, seq_error=0, busy=0.
  - Mid-frame reset discards the partial frame; the FFT core shares rst_in.
- FIFO (show-ahead; head visible on fft_in_data):
  - Push on audio_sample_valid.
  - Full and no pop this cycle: sample dropped, overflow set.
  - Full with a pop in the same cycle: push accepted, no overflow.
  - Push to an empty FIFO: fft_in_valid rises the next cycle (1-cycle latency); a sample is never passed through combinationally.
- State FEED:
  - fft_in_valid = FIFO not empty.
  - Pop when fft_in_valid & fft_ready; in_idx++ on each pop.
  - fft_in_last = fft_in_valid & (in_idx==FFT_SIZE-1).
  - Pop with fft_in_last -> in_idx=0, go to UNLOAD.
  - fft_in_data holds steady while valid & !ready.
- State UNLOAD:
  - fft_in_valid=0; FIFO keeps accepting pushes.
  - fft_out_ready=1, busy=1.
  - Each bin_valid: bin_index++.
  - bin_valid & fft_out_last -> bin_index=0, frame_count++, frame_done pulses the next cycle, go to FEED.
- FEED never issues samples of frame n+1 before frame n is fully drained.
- fft_out_valid while in FEED: ignored, fft_out_ready=0.
- Counters wrap: bin_index and in_idx by FFT_SIZE, frame_count at 2^16.

Optional Feature:
- Macro: FFT_SEQ_CHECK_EN.
- Defined:
  - seq_error set if fft_out_last is accepted with bin_index != FFT_SIZE-1.
  - seq_error set if bin_index reaches FFT_SIZE-1 and that bin is accepted without fft_out_last.
  - The state machine still follows fft_out_last.
- Undefined: seq_error tied 0; no check logic.

Test Plan (FFT_SIZE=16, FIFO_DEPTH=4 unless noted):
- Samples 1..16, one strobe per 51 clk, fft_ready=1 -> 16 input beats with data 1..16; fft_in_last only on value 16; state UNLOAD; fft_in_valid=0 afterwards.
- fft_ready=0 while 6 strobes arrive (values 1..6) -> first 4 buffered, 5 and 6 dropped, overflow=1 and stays 1; after fft_ready=1 beats are 1,2,3,4 in order.
- FIFO full with a push and pop in the same cycle -> count stays 4, overflow stays 0.
- Model returns 16 output beats with fft_out_last on beat 16 -> bin_index 0..15 aligned to bin_valid; frame_done pulse 1 cycle later; frame_count=1; busy falls.
- 8 samples pushed during UNLOAD -> held in FIFO, streamed first in next frame in order; 3 frames run back to back -> frame_count=3.
- rst_in asserted after 7 input beats -> next cycle all outputs at reset values; then 16 new samples give a clean frame.
- FFT_SEQ_CHECK_EN defined, fft_out_last on beat 12 -> seq_error=1; return to FEED.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer between the window output and a streaming FFT core: buffers samples,
// feeds FFT_SIZE-sample frames, drains and indexes the bins. Optional check: FFT_SEQ_CHECK_EN.
module fft_frame_sequencer #(
   parameter int unsigned FFT_SIZE     = 4096,
   parameter int unsigned SAMPLE_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic signed [SAMPLE_WIDTH-1:0] in_sample,
   input  logic                          audio_sample_valid,
   output logic [2*SAMPLE_WIDTH-1:0]     fft_in_data,
   output logic                          fft_in_valid,
   output logic                          fft_in_last,
   input  logic                          fft_ready,
   input  logic                          fft_out_valid,
   input  logic                          fft_out_last,
   output logic                          fft_out_ready,
   output logic                          bin_valid,
   output logic [$clog2(FFT_SIZE)-1:0]   bin_index,
   output logic                          frame_done,
   output logic [15:0]                   frame_count,
   output logic                          overflow,
   output logic                          seq_error,
   output logic                          busy
);

   localparam int unsigned IdxW = $clog2(FFT_SIZE);
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(FFT_SIZE - 1);
   localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(FIFO_DEPTH);

   localparam logic [0:0] StFeed   = 1'b0;
   localparam logic [0:0] StUnload = 1'b1;

   logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]           count_q, count_d;
   logic [0:0]              state_q, state_d;
   logic [IdxW-1:0]         in_idx_q, in_idx_d, bin_idx_q, bin_idx_d;
   logic [15:0]             frame_cnt_q, frame_cnt_d;
   logic                    done_q, done_d, ovf_q, ovf_d;
   logic                    feed, fifo_empty, fifo_full, push, pop;

   assign feed       = (state_q == StFeed);
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CntFull);

   assign fft_in_valid  = feed & ~fifo_empty;
   assign fft_in_last   = fft_in_valid & (in_idx_q == IdxLast);
   assign fft_in_data   = {{SAMPLE_WIDTH{1'b0}}, mem_q[rd_ptr_q]};
   assign pop           = fft_in_valid & fft_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push          = audio_sample_valid & (~fifo_full | pop);
   assign fft_out_ready = ~feed;
   assign bin_valid     = fft_out_valid & fft_out_ready;
   assign busy          = ~feed;
   assign bin_index     = bin_idx_q;
   assign frame_done    = done_q;
   assign frame_count   = frame_cnt_q;
   assign overflow      = ovf_q;

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
      state_d     = state_q;
      in_idx_d    = in_idx_q;
      bin_idx_d   = bin_idx_q;
      frame_cnt_d = frame_cnt_q;
      done_d      = bin_valid & fft_out_last;
      ovf_d       = ovf_q | (audio_sample_valid & fifo_full & ~pop);
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         if (fft_in_last) begin
            in_idx_d = '0;
            state_d  = StUnload;
         end else begin
            in_idx_d = in_idx_q + 1'b1;
         end
      end
      if (bin_valid) begin
         if (fft_out_last) begin
            bin_idx_d   = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = StFeed;
         end else begin
            bin_idx_d = bin_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_sample;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= StFeed;
         in_idx_q    <= '0;
         bin_idx_q   <= '0;
         frame_cnt_q <= '0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         in_idx_q    <= in_idx_d;
         bin_idx_q   <= bin_idx_d;
         frame_cnt_q <= frame_cnt_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
      end
   end

`ifdef FFT_SEQ_CHECK_EN
   logic serr_q, serr_d;

   // Last must coincide exactly with the final bin index; either mismatch is an error.
   always_comb begin
      serr_d = serr_q | (bin_valid & (fft_out_last ^ (bin_idx_q == IdxLast)));
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         serr_q <= 1'b0;
      end else begin
         serr_q <= serr_d;
      end
   end

   assign seq_error = serr_q;
`else
   assign seq_error = 1'b0;
`endif

endmodule
